// File: rtl/rdy_vld_pack.sv
// Ready/valid width packer: gathers RATIO input beats of DWIDTH bits into one
// output word with a per-lane keep mask, closing early on last_in.
module rdy_vld_pack #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned RATIO  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vld_in,
  input  logic [DWIDTH-1:0]        din,
  input  logic                     last_in,
  output logic                     rdy_out,
  output logic                     vld_out,
  output logic [DWIDTH*RATIO-1:0]  dout,
  output logic [RATIO-1:0]         keep_out,
  output logic                     last_out,
  input  logic                     rdy_in
);

  localparam int unsigned CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned OW = DWIDTH * RATIO;
  localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

  logic [CW-1:0]     r_cnt;
  logic [OW-1:0]     r_acc;
  logic              r_vld;
  logic [OW-1:0]     r_dout;
  logic [RATIO-1:0]  r_keep;
  logic              r_last;

  logic              w_accept;
  logic              w_complete;
  logic [CW-1:0]     w_cnt_nxt;
  logic [OW-1:0]     w_acc_nxt;
  logic              w_vld_nxt;
  logic [OW-1:0]     w_word;
  logic [RATIO-1:0]  w_keep;

  // Upstream may push whenever the output slot is empty or being drained now.
  assign rdy_out    = ~r_vld | rdy_in;
  assign w_accept   = vld_in & rdy_out;
  assign w_complete = w_accept & (last_in | (r_cnt == LAST_LANE));

  // Candidate word: stored lanes below cnt, incoming beat at cnt, zeros above.
  always_comb begin
    w_word    = '0;
    w_keep    = '0;
    w_acc_nxt = r_acc;
    w_cnt_nxt = r_cnt;
    w_vld_nxt = r_vld;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (CW'(k) < r_cnt) begin
        w_word[k*DWIDTH +: DWIDTH] = r_acc[k*DWIDTH +: DWIDTH];
        w_keep[k]                  = 1'b1;
      end else if (CW'(k) == r_cnt) begin
        w_word[k*DWIDTH +: DWIDTH] = din;
        w_keep[k]                  = 1'b1;
      end
    end
    if (w_complete) begin
      w_acc_nxt = '0;
      w_cnt_nxt = '0;
    end else if (w_accept) begin
      for (int unsigned k = 0; k < RATIO; k++) begin
        if (CW'(k) == r_cnt) begin
          w_acc_nxt[k*DWIDTH +: DWIDTH] = din;
        end
      end
      w_cnt_nxt = r_cnt + CW'(1);
    end
    // A completion in the same cycle as a drain reloads with no bubble.
    if (w_complete) begin
      w_vld_nxt = 1'b1;
    end else if (r_vld & rdy_in) begin
      w_vld_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_vld  <= 1'b0;
      r_dout <= '0;
      r_keep <= '0;
      r_last <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_acc <= w_acc_nxt;
      r_vld <= w_vld_nxt;
      if (w_complete) begin
        r_dout <= w_word;
        r_keep <= w_keep;
        r_last <= last_in;
      end
    end
  end

  assign vld_out  = r_vld;
  assign dout     = r_dout;
  assign keep_out = r_keep;
  assign last_out = r_last;

endmodule

// File: tb/tb_rdy_vld_pack.sv
// Directed bench for rdy_vld_pack (DWIDTH=32, RATIO=4): vector table plus
// hand-written streaming and mid-word reset sequences.
module tb_rdy_vld_pack;

  localparam int unsigned DW = 32;
  localparam int unsigned RT = 4;
  localparam int unsigned OW = DW * RT;

  logic          clk = 1'b0;
  logic          rst;
  logic          vld_in;
  logic [DW-1:0] din;
  logic          last_in;
  logic          rdy_out;
  logic          vld_out;
  logic [OW-1:0] dout;
  logic [RT-1:0] keep_out;
  logic          last_out;
  logic          rdy_in;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic          vld;
    logic [DW-1:0] d;
    logic          last;
    logic          rdy;
    logic          exp_rdy;
    logic          exp_vld;
    logic [OW-1:0] exp_dout;
    logic [RT-1:0] exp_keep;
    logic          exp_last;
  } vec_t;

  vec_t vecs[$];

  rdy_vld_pack #(.DWIDTH(DW), .RATIO(RT)) dut (
    .clk      (clk),
    .rst      (rst),
    .vld_in   (vld_in),
    .din      (din),
    .last_in  (last_in),
    .rdy_out  (rdy_out),
    .vld_out  (vld_out),
    .dout     (dout),
    .keep_out (keep_out),
    .last_out (last_out),
    .rdy_in   (rdy_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [DW-1:0] d, input logic l, input logic r,
                     input logic er, input logic ev, input logic [OW-1:0] ed,
                     input logic [RT-1:0] ek, input logic el);
    vec_t t;
    t.vld = v; t.d = d; t.last = l; t.rdy = r;
    t.exp_rdy = er; t.exp_vld = ev; t.exp_dout = ed; t.exp_keep = ek; t.exp_last = el;
    vecs.push_back(t);
  endtask

  // Drive one cycle: rdy_out is checked before the edge, registered outputs after it.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    vld_in = v.vld; din = v.d; last_in = v.last; rdy_in = v.rdy;
    #1 chk({tag, " rdy_out"}, OW'(rdy_out), OW'(v.exp_rdy));
    @(posedge clk);
    #1;
    chk({tag, " vld_out"}, OW'(vld_out), OW'(v.exp_vld));
    chk({tag, " dout"}, dout, v.exp_dout);
    chk({tag, " keep_out"}, OW'(keep_out), OW'(v.exp_keep));
    chk({tag, " last_out"}, OW'(last_out), OW'(v.exp_last));
  endtask

  localparam logic [OW-1:0] W1234 = 128'h00000004_00000003_00000002_00000001;
  localparam logic [OW-1:0] WAB   = 128'h00000000_00000000_0000000B_0000000A;
  localparam logic [OW-1:0] W56   = 128'h00000000_00000000_00000006_00000005;
  localparam logic [OW-1:0] W99   = 128'h00000000_00000000_00000000_00000099;

  initial begin
    logic [OW-1:0] exp_w;

    // Full word 1..4, last on beat 4
    add(1, 32'h1, 0, 1,  1, 0, '0,    4'h0, 0);
    add(1, 32'h2, 0, 1,  1, 0, '0,    4'h0, 0);
    add(1, 32'h3, 0, 1,  1, 0, '0,    4'h0, 0);
    add(1, 32'h4, 1, 1,  1, 1, W1234, 4'hF, 1);
    // Short packet A,B; first beat drains the pending word
    add(1, 32'hA, 0, 1,  1, 0, W1234, 4'hF, 1);
    add(1, 32'hB, 1, 1,  1, 1, WAB,   4'h3, 1);
    // Long packet 1..6
    add(1, 32'h1, 0, 1,  1, 0, WAB,   4'h3, 1);
    add(1, 32'h2, 0, 1,  1, 0, WAB,   4'h3, 1);
    add(1, 32'h3, 0, 1,  1, 0, WAB,   4'h3, 1);
    add(1, 32'h4, 0, 1,  1, 1, W1234, 4'hF, 0);
    add(1, 32'h5, 0, 1,  1, 0, W1234, 4'hF, 0);
    add(1, 32'h6, 1, 1,  1, 1, W56,   4'h3, 1);
    // Backpressure for 5 cycles; offered beats must be refused
    for (int i = 0; i < 5; i++)
      add(logic'(i % 2), 32'hDEAD, 1, 0,  0, 1, W56, 4'h3, 1);
    add(0, 32'h0, 0, 1,  1, 0, W56, 4'h3, 1);
    // Single-beat packet at lane 0
    add(1, 32'h99, 1, 1,  1, 1, W99, 4'h1, 1);
    add(0, 32'h0,  0, 1,  1, 0, W99, 4'h1, 1);

    rst = 1'b1; vld_in = 1'b0; din = '0; last_in = 1'b0; rdy_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset vld_out",  OW'(vld_out),  '0);
    chk("reset dout",     dout,          '0);
    chk("reset keep_out", OW'(keep_out), '0);
    chk("reset last_out", OW'(last_out), '0);
    chk("reset rdy_out",  OW'(rdy_out),  OW'(1'b1));
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Streaming 16 beats: one word every 4th cycle, no bubbles
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      vld_in = 1'b1; din = 32'h100 + 32'(i); last_in = (i == 15); rdy_in = 1'b1;
      #1 chk($sformatf("stream%0d rdy_out", i), OW'(rdy_out), OW'(1'b1));
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d vld_out", i), OW'(vld_out), OW'((i % 4) == 3));
      if ((i % 4) == 3) begin
        for (int k = 0; k < 4; k++) exp_w[k*DW +: DW] = 32'h100 + 32'(i - 3 + k);
        chk($sformatf("stream%0d dout", i), dout, exp_w);
        chk($sformatf("stream%0d keep_out", i), OW'(keep_out), OW'(4'hF));
        chk($sformatf("stream%0d last_out", i), OW'(last_out), OW'(i == 15));
      end
    end
    @(negedge clk);
    vld_in = 1'b0; last_in = 1'b0;
    @(posedge clk);
    #1 chk("stream drain vld_out", OW'(vld_out), '0);

    // Reset mid-word, with a completing beat offered during reset
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vld_in = 1'b1; din = 32'h11 * 32'(i + 1); last_in = 1'b0; rdy_in = 1'b1;
      @(posedge clk);
      #1 chk($sformatf("midrst beat%0d vld_out", i), OW'(vld_out), '0);
    end
    @(negedge clk);
    rst = 1'b1; din = 32'h33; last_in = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst rst vld_out",  OW'(vld_out),  '0);
    chk("midrst rst dout",     dout,          '0);
    chk("midrst rst keep_out", OW'(keep_out), '0);
    @(negedge clk);
    rst = 1'b0; din = 32'h7; last_in = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst post vld_out",  OW'(vld_out),  OW'(1'b1));
    chk("midrst post dout",     dout,          OW'(32'h7));
    chk("midrst post keep_out", OW'(keep_out), OW'(4'h1));
    chk("midrst post last_out", OW'(last_out), OW'(1'b1));
    @(negedge clk);
    vld_in = 1'b0; last_in = 1'b0;
    @(posedge clk);
    #1 chk("midrst drain vld_out", OW'(vld_out), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rdy_vld_pack.md
RDY_VLD_PACK -- requirements
Module: rdy_vld_pack

Interface
REQ-001 Parameter DWIDTH, default 32, input beat width in bits.
REQ-002 Parameter RATIO, default 4, input beats per packed output word; legal range 2..16.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 vld_in  input  1  upstream beat valid.
REQ-006 din  input  DWIDTH  upstream beat data.
REQ-007 last_in  input  1  upstream beat closes the current packet.
REQ-008 rdy_out  output  1  block accepts a beat this cycle.
REQ-009 vld_out  output  1  packed word valid.
REQ-010 dout  output  DWIDTH*RATIO  packed word; lane k = bits [k*DWIDTH +: DWIDTH].
REQ-011 keep_out  output  RATIO  per-lane valid mask for dout.
REQ-012 last_out  output  1  packed word ends a packet.
REQ-013 rdy_in  input  1  downstream accepts the packed word.

Function
REQ-014 The block SHALL accept a beat when vld_in & rdy_out, and transfer a word when vld_out & rdy_in.
REQ-015 rdy_out SHALL be ~vld_out | rdy_in, with no dependence on vld_in, din or last_in.
REQ-016 A lane counter cnt (0..RATIO-1) SHALL select the lane for each accepted beat; the first beat after reset or completion goes to lane 0 (LSBs).
REQ-017 An accepted beat with cnt < RATIO-1 and last_in=0 SHALL be stored in accumulator lane cnt, and cnt SHALL increment.
REQ-018 An accepted beat with cnt == RATIO-1 or last_in=1 SHALL complete the word.
REQ-019 On completion, the output register SHALL load:
  - dout: accumulator lanes 0..cnt-1, din in lane cnt, zeros in lanes above cnt.
  - keep_out: bits 0..cnt set, all others clear.
  - last_out: last_in.
REQ-020 On completion, cnt SHALL return to 0 and all accumulator lanes SHALL clear to zero in the same cycle.
REQ-021 Latency: the completing beat accepted at edge N SHALL produce vld_out=1 after edge N.
REQ-022 vld_out SHALL set on completion, clear on vld_out & rdy_in with no completion that cycle, and otherwise hold.
REQ-023 Simultaneous drain and completion in one cycle SHALL load the new word with vld_out remaining 1, so there is no bubble.
REQ-024 While vld_out=1 and rdy_in=0, dout, keep_out and last_out SHALL hold stable, and rdy_out SHALL be 0.
REQ-025 Sustained vld_in=1 and rdy_in=1 SHALL give one accepted beat per cycle and one output word per RATIO beats.
REQ-026 A beat with last_in=1 at cnt=0 SHALL produce a single-lane word with keep_out=1.
REQ-027 A packet of length L SHALL produce ceil(L/RATIO) words; only the final word carries last_out=1, and every non-final word has keep_out all ones.
REQ-028 dout, keep_out and last_out SHALL change only when the output register loads.
REQ-029 No beat SHALL be lost or duplicated under any pattern of vld_in and rdy_in.

Reset
REQ-030 While rst=1 at a rising edge, the following SHALL become 0 after that edge: vld_out, dout, keep_out, last_out, cnt and all accumulator lanes.
REQ-031 After reset, rdy_out SHALL be 1 via REQ-015.
REQ-032 A partially accumulated word at reset SHALL be discarded, and no output word is produced from it.
REQ-033 rst SHALL take priority over any simultaneous accept or transfer.

Verification (DWIDTH=32, RATIO=4)
REQ-034 Full word: beats 0x1,0x2,0x3,0x4, last on 4th, rdy_in=1 -> one word dout=0x00000004_00000003_00000002_00000001, keep_out=0xF, last_out=1, vld_out high 1 cycle after beat 4.
REQ-035 Short packet: beats 0xA,0xB, last on 2nd -> dout=0x00000000_00000000_0000000B_0000000A, keep_out=0x3, last_out=1.
REQ-036 Long packet: 6 beats 0x1..0x6, last on 6th -> word1 keep_out=0xF with last_out=0, then word2 lanes 0x5,0x6 with keep_out=0x3 and last_out=1.
REQ-037 Backpressure: rdy_in=0 for 5 cycles with word pending -> rdy_out=0, outputs stable; rdy_in=1 -> word transfers once, rdy_out=1 the same cycle.
REQ-038 Streaming: 16 consecutive beats, vld_in=1, rdy_in=1, last on 16th -> 4 words on consecutive-by-4 cycles, no bubbles, last_out only on the 4th word.
REQ-039 Reset mid-word: 2 beats accepted, rst pulsed for 1 cycle, then 0x7 with last_in=1 -> dout lane0=0x7, keep_out=0x1, and no stale lanes.
